// File: rtl/mips_pkg.sv
// Shared MIPS generic definitions: datapath width, register-file address type
// and the operand-source selector used by the forwarding logic.
package mips_pkg;

  localparam int Data_Width = 32;
  localparam int RF_ADDR_W  = 5;

  typedef logic [RF_ADDR_W-1:0] rfa_t;

  typedef enum logic [2:0] {
    FWD_RF,
    FWD_EX,
    FWD_MEM,
    FWD_WB,
    FWD_ZERO
  } fwd_sel_t;

endpackage

// File: rtl/mips_fwd_mux.sv
// Per-source operand resolver: $zero, then EX > MEM > WB forwards, else the
// register-file read data. Purely combinational.
module mips_fwd_mux
  import mips_pkg::*;
#(
  parameter bit EX_FWD_EN = 1'b1
) (
  input  rfa_t                  addr,
  input  logic [Data_Width-1:0] rd,
  input  logic                  ex_wen,
  input  logic                  ex_is_load,
  input  rfa_t                  ex_wa,
  input  logic [Data_Width-1:0] ex_wd,
  input  logic                  mem_wen,
  input  rfa_t                  mem_wa,
  input  logic [Data_Width-1:0] mem_wd,
  input  logic                  wb_wen,
  input  rfa_t                  wb_wa,
  input  logic [Data_Width-1:0] wb_wd,
  output logic [Data_Width-1:0] operand,
  output fwd_sel_t              sel
);

  always_comb begin
    sel     = FWD_RF;
    operand = rd;
    if (addr == '0) begin
      sel     = FWD_ZERO;
      operand = '0;
    end else if (EX_FWD_EN && ex_wen && !ex_is_load && (ex_wa == addr)) begin
      sel     = FWD_EX;
      operand = ex_wd;
    end else if (mem_wen && (mem_wa == addr)) begin
      sel     = FWD_MEM;
      operand = mem_wd;
    end else if (wb_wen && (wb_wa == addr)) begin
      // same-edge register-file write is not yet visible on rd
      sel     = FWD_WB;
      operand = wb_wd;
    end
  end

endmodule

// File: rtl/mips_operand_stage.sv
// Decode-to-execute operand stage: forwarding, load-use stall and ID/EX register.
// Optional statistics counters are enabled with `define MIPS_OPERAND_STATS_EN.
module mips_operand_stage
  import mips_pkg::Data_Width;
  import mips_pkg::rfa_t;
  import mips_pkg::fwd_sel_t;
#(
  parameter int FWD_EX = 1
`ifdef MIPS_OPERAND_STATS_EN
  ,
  parameter int CNT_W  = 16
`endif
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  id_valid,
  input  rfa_t                  id_rs,
  input  rfa_t                  id_rt,
  input  logic                  id_uses_rs,
  input  logic                  id_uses_rt,
  input  logic [Data_Width-1:0] rd1,
  input  logic [Data_Width-1:0] rd2,
  input  logic                  ex_wen,
  input  logic                  ex_is_load,
  input  rfa_t                  ex_wa,
  input  logic [Data_Width-1:0] ex_wd,
  input  logic                  mem_wen,
  input  rfa_t                  mem_wa,
  input  logic [Data_Width-1:0] mem_wd,
  input  logic                  wb_wen,
  input  rfa_t                  wb_wa,
  input  logic [Data_Width-1:0] wb_wd,
  input  logic                  ex_ready,
  input  logic                  flush,
`ifdef MIPS_OPERAND_STATS_EN
  output logic [CNT_W-1:0]      stall_cnt,
  output logic [CNT_W-1:0]      fwd_cnt,
`endif
  output logic                  id_stall,
  output logic                  op_valid,
  output logic [Data_Width-1:0] op_a,
  output logic [Data_Width-1:0] op_b,
  output rfa_t                  op_rs,
  output rfa_t                  op_rt
);

  localparam bit EX_FWD_EN = (FWD_EX != 0);

  logic [Data_Width-1:0] res_a, res_b;
  fwd_sel_t              sel_a, sel_b;
  logic                  hz, hold, capture;

  logic                  op_valid_q, op_valid_d;
  logic [Data_Width-1:0] op_a_q, op_a_d, op_b_q, op_b_d;
  rfa_t                  op_rs_q, op_rs_d, op_rt_q, op_rt_d;

  mips_fwd_mux #(.EX_FWD_EN(EX_FWD_EN)) u_fwd_a (
    .addr(id_rs), .rd(rd1),
    .ex_wen(ex_wen), .ex_is_load(ex_is_load), .ex_wa(ex_wa), .ex_wd(ex_wd),
    .mem_wen(mem_wen), .mem_wa(mem_wa), .mem_wd(mem_wd),
    .wb_wen(wb_wen), .wb_wa(wb_wa), .wb_wd(wb_wd),
    .operand(res_a), .sel(sel_a)
  );

  mips_fwd_mux #(.EX_FWD_EN(EX_FWD_EN)) u_fwd_b (
    .addr(id_rt), .rd(rd2),
    .ex_wen(ex_wen), .ex_is_load(ex_is_load), .ex_wa(ex_wa), .ex_wd(ex_wd),
    .mem_wen(mem_wen), .mem_wa(mem_wa), .mem_wd(mem_wd),
    .wb_wen(wb_wen), .wb_wa(wb_wa), .wb_wd(wb_wd),
    .operand(res_b), .sel(sel_b)
  );

  // Without EX forwarding every EX match must wait a cycle, just like a load.
  always_comb begin
    hz = id_valid && ex_wen && (ex_wa != '0) && (ex_is_load || !EX_FWD_EN) &&
         ((id_uses_rs && (ex_wa == id_rs)) || (id_uses_rt && (ex_wa == id_rt)));
    hold     = op_valid_q && !ex_ready;
    id_stall = hz || hold;
    capture  = !flush && !hold && !hz;
  end

  always_comb begin
    op_valid_d = op_valid_q;
    op_a_d     = op_a_q;
    op_b_d     = op_b_q;
    op_rs_d    = op_rs_q;
    op_rt_d    = op_rt_q;
    if (flush || (!hold && hz)) begin
      op_valid_d = 1'b0;
    end else if (capture) begin
      op_valid_d = id_valid;
      op_a_d     = res_a;
      op_b_d     = res_b;
      op_rs_d    = id_rs;
      op_rt_d    = id_rt;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      op_valid_q <= 1'b0;
      op_a_q     <= '0;
      op_b_q     <= '0;
      op_rs_q    <= '0;
      op_rt_q    <= '0;
    end else begin
      op_valid_q <= op_valid_d;
      op_a_q     <= op_a_d;
      op_b_q     <= op_b_d;
      op_rs_q    <= op_rs_d;
      op_rt_q    <= op_rt_d;
    end
  end

  assign op_valid = op_valid_q;
  assign op_a     = op_a_q;
  assign op_b     = op_b_q;
  assign op_rs    = op_rs_q;
  assign op_rt    = op_rt_q;

`ifdef MIPS_OPERAND_STATS_EN
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d, fwd_cnt_q, fwd_cnt_d;
  logic             fwd_any;

  always_comb begin
    fwd_any = ((sel_a != mips_pkg::FWD_RF) && (sel_a != mips_pkg::FWD_ZERO)) ||
              ((sel_b != mips_pkg::FWD_RF) && (sel_b != mips_pkg::FWD_ZERO));
    stall_cnt_d = stall_cnt_q;
    fwd_cnt_d   = fwd_cnt_q;
    if (hz && (stall_cnt_q != '1)) stall_cnt_d = stall_cnt_q + 1'b1;
    if (capture && id_valid && fwd_any && (fwd_cnt_q != '1)) fwd_cnt_d = fwd_cnt_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt_q <= '0;
      fwd_cnt_q   <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
      fwd_cnt_q   <= fwd_cnt_d;
    end
  end

  assign stall_cnt = stall_cnt_q;
  assign fwd_cnt   = fwd_cnt_q;
`else
  logic unused_sel;
  assign unused_sel = ^{sel_a, sel_b};
`endif

endmodule
